// File: rtl/ddm_if.sv
// ddm packet and configuration bus bundle.
// slave is the ddm side; master is the upstream/downstream environment.
interface ddm_if;
    logic [255:0]  in_ddm_md;
    logic          in_ddm_md_wr;
    logic          out_ddm_md_alf;
    logic [1023:0] in_ddm_phv;
    logic          in_ddm_phv_wr;
    logic          out_ddm_phv_alf;
    logic [255:0]  out_ddm_md;
    logic          out_ddm_md_wr;
    logic          in_ddm_md_alf;
    logic [1023:0] out_ddm_phv;
    logic          out_ddm_phv_wr;
    logic          in_ddm_phv_alf;
    logic [133:0]  cin_ddm_data;
    logic          cin_ddm_data_wr;
    logic          cout_ddm_ready;
    logic [133:0]  cout_ddm_data;
    logic          cout_ddm_data_wr;
    logic          cin_ddm_ready;

    modport slave (
        input  in_ddm_md, in_ddm_md_wr, in_ddm_phv, in_ddm_phv_wr,
        input  in_ddm_md_alf, in_ddm_phv_alf,
        input  cin_ddm_data, cin_ddm_data_wr, cin_ddm_ready,
        output out_ddm_md_alf, out_ddm_phv_alf,
        output out_ddm_md, out_ddm_md_wr, out_ddm_phv, out_ddm_phv_wr,
        output cout_ddm_ready, cout_ddm_data, cout_ddm_data_wr
    );

    modport master (
        output in_ddm_md, in_ddm_md_wr, in_ddm_phv, in_ddm_phv_wr,
        output in_ddm_md_alf, in_ddm_phv_alf,
        output cin_ddm_data, cin_ddm_data_wr, cin_ddm_ready,
        input  out_ddm_md_alf, out_ddm_phv_alf,
        input  out_ddm_md, out_ddm_md_wr, out_ddm_phv, out_ddm_phv_wr,
        input  cout_ddm_ready, cout_ddm_data, cout_ddm_data_wr
    );
endinterface

// File: rtl/ddm.sv
// Discard/delivery module: drops flagged local packets, forwards the rest,
// and exposes drop/forward counters over the configuration chain.
module ddm_fifo #(
    parameter int W  = 256,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          wr,
    input  logic [W-1:0]  din,
    input  logic          rd,
    output logic [W-1:0]  dout,
    output logic [AW:0]   cnt
);
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_wr;
    logic          do_rd;

    assign do_wr = wr && (cnt != FULL);
    assign do_rd = rd && (cnt != '0);
    assign dout  = mem[rp];

    always_ff @(posedge clk) begin
        if (srst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= din;
    end
endmodule

module ddm #(
    parameter logic [7:0] LMID    = 8'd5,
    parameter logic [7:0] NMID    = 8'd6,
    parameter logic [7:0] CFG_MID = 8'd8
) (
    input logic clk,
    input logic rst_n,
    ddm_if.slave bus
);
    typedef enum logic {IDLE_S, GAP_S} state_t;

    state_t        state, state_n;
    logic          pop;
    logic [255:0]  md_head;
    logic [1023:0] phv_head;
    logic [8:0]    md_cnt;
    logic [8:0]    phv_cnt;
    logic          is_local;
    logic          is_drop;
    logic [255:0]  md_q;
    logic          md_wr_q;
    logic [1023:0] phv_q;
    logic          phv_wr_q;
    logic [63:0]   fwd_pkt_cnt;
    logic [63:0]   drop_pkt_cnt;
    logic [63:0]   drop_byte_cnt;

    ddm_fifo #(.W(256), .AW(8)) u_md_fifo (
        .clk(clk), .srst(!rst_n),
        .wr(bus.in_ddm_md_wr), .din(bus.in_ddm_md),
        .rd(pop), .dout(md_head), .cnt(md_cnt)
    );

    ddm_fifo #(.W(1024), .AW(8)) u_phv_fifo (
        .clk(clk), .srst(!rst_n),
        .wr(bus.in_ddm_phv_wr), .din(bus.in_ddm_phv),
        .rd(pop), .dout(phv_head), .cnt(phv_cnt)
    );

    assign bus.out_ddm_md_alf  = bus.in_ddm_md_alf  || (md_cnt  > 9'd250);
    assign bus.out_ddm_phv_alf = bus.in_ddm_phv_alf || (phv_cnt > 9'd250);

    assign is_local = (md_head[87:80] == LMID);
    assign is_drop  = is_local && md_head[108];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE_S;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE_S: begin
                if (md_cnt != '0 && phv_cnt != '0 &&
                    !bus.in_ddm_md_alf && !bus.in_ddm_phv_alf) begin
                    pop     = 1'b1;
                    state_n = GAP_S;
                end
            end
            GAP_S: state_n = IDLE_S;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_q     <= '0;
            md_wr_q  <= 1'b0;
            phv_q    <= '0;
            phv_wr_q <= 1'b0;
        end else begin
            md_wr_q  <= pop && !is_drop;
            phv_wr_q <= pop && !is_drop;
            if (pop && !is_drop) begin
                md_q  <= is_local ? {md_head[255:88], NMID, md_head[79:0]}
                                  : md_head;
                phv_q <= phv_head;
            end else begin
                md_q  <= '0;
                phv_q <= '0;
            end
        end
    end

    assign bus.out_ddm_md     = md_q;
    assign bus.out_ddm_md_wr  = md_wr_q;
    assign bus.out_ddm_phv    = phv_q;
    assign bus.out_ddm_phv_wr = phv_wr_q;

    logic [133:0] cd;
    logic         c_hdr;
    logic         c_tail;
    logic         self_wr;
    logic         self_rd;
    logic         clear_pulse;
    logic         cw_flag;
    logic         consume;
    logic [31:0]  c_addr;
    logic [31:0]  rd_val;
    logic         rd_hit;
    logic [133:0] cout_q;
    logic         cout_wr_q;

    assign cd      = bus.cin_ddm_data;
    assign c_addr  = cd[95:64];
    assign c_hdr   = bus.cin_ddm_data_wr && (cd[133:132] == 2'b01);
    assign c_tail  = bus.cin_ddm_data_wr && (cd[133:132] == 2'b10);
    assign self_wr = c_hdr && (cd[126:124] == 3'b010) && (cd[103:96] == CFG_MID);
    assign self_rd = c_hdr && (cd[126:124] == 3'b001) && (cd[103:96] == CFG_MID);
    assign clear_pulse = self_wr && (c_addr == 32'h8000_0000) && cd[0];
    // Everything of a self-addressed write up to its tail is swallowed.
    assign consume = self_wr || (cw_flag && bus.cin_ddm_data_wr);

    always_comb begin
        rd_val = '0;
        rd_hit = 1'b1;
        case (c_addr)
            32'h8000_0008: rd_val = fwd_pkt_cnt[31:0];
            32'h8000_0009: rd_val = fwd_pkt_cnt[63:32];
            32'h8000_000A: rd_val = drop_pkt_cnt[31:0];
            32'h8000_000B: rd_val = drop_pkt_cnt[63:32];
            32'h8000_000C: rd_val = drop_byte_cnt[31:0];
            32'h8000_000D: rd_val = drop_byte_cnt[63:32];
            default:       rd_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_pkt_cnt   <= '0;
            drop_pkt_cnt  <= '0;
            drop_byte_cnt <= '0;
        end else if (clear_pulse) begin
            fwd_pkt_cnt   <= '0;
            drop_pkt_cnt  <= '0;
            drop_byte_cnt <= '0;
        end else if (pop) begin
            if (is_local && !is_drop) fwd_pkt_cnt <= fwd_pkt_cnt + 64'd1;
            if (is_drop) begin
                drop_pkt_cnt  <= drop_pkt_cnt + 64'd1;
                drop_byte_cnt <= drop_byte_cnt + {52'b0, md_head[107:96]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw_flag   <= 1'b0;
            cout_q    <= '0;
            cout_wr_q <= 1'b0;
        end else begin
            if (self_wr)               cw_flag <= 1'b1;
            else if (cw_flag && c_tail) cw_flag <= 1'b0;
            cout_wr_q <= bus.cin_ddm_data_wr && !consume;
            if (!bus.cin_ddm_data_wr || consume)
                cout_q <= '0;
            else if (self_rd && rd_hit)
                cout_q <= {cd[133:128], 4'b1011, cd[123:112], cd[103:96],
                           cd[111:104], cd[95:32], rd_val};
            else
                cout_q <= cd;
        end
    end

    assign bus.cout_ddm_data    = cout_q;
    assign bus.cout_ddm_data_wr = cout_wr_q;
    assign bus.cout_ddm_ready   = bus.cin_ddm_ready;
endmodule

// File: tb/tb_ddm.sv
// Directed bench for ddm: forward, drop, bypass, backpressure,
// reset, and configuration read/clear.
module tb_ddm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ddm_if bus ();
    ddm dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int push_cyc = 0;

    typedef struct {
        logic [255:0]  md;
        logic [1023:0] phv;
        logic          phv_wr;
        int            c;
    } pkt_t;

    pkt_t         outq[$];
    logic [133:0] cfgq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_ddm_md_wr)
            outq.push_back('{bus.out_ddm_md, bus.out_ddm_phv, bus.out_ddm_phv_wr, cyc});
        if (bus.cout_ddm_data_wr)
            cfgq.push_back(bus.cout_ddm_data);
    end

    task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_phv(string tag, logic [1023:0] got, logic [1023:0] exp);
        for (int k = 0; k < 4; k++)
            check($sformatf("%s%0d", tag, k), got[k*256 +: 256], exp[k*256 +: 256]);
    endtask

    function automatic logic [255:0] mk_md(logic [7:0] id, logic drp,
                                           logic [11:0] len, logic [31:0] seq);
        logic [255:0] m;
        m = '0;
        m[255:224] = 32'hA5A5_0000 ^ seq;
        m[108] = drp;
        m[107:96] = len;
        m[87:80] = id;
        m[31:0] = seq;
        return m;
    endfunction

    function automatic logic [1023:0] mk_phv(logic [31:0] seq);
        return {32{32'hC0DE_0000 + seq}};
    endfunction

    task automatic push(logic [255:0] md, logic [1023:0] phv);
        @(negedge clk);
        bus.in_ddm_md = md;
        bus.in_ddm_phv = phv;
        bus.in_ddm_md_wr = 1'b1;
        bus.in_ddm_phv_wr = 1'b1;
        @(negedge clk);
        bus.in_ddm_md_wr = 1'b0;
        bus.in_ddm_phv_wr = 1'b0;
        push_cyc = cyc;
    endtask

    task automatic cfg_send(logic [133:0] h, logic [133:0] t);
        @(negedge clk);
        bus.cin_ddm_data = h;
        bus.cin_ddm_data_wr = 1'b1;
        @(negedge clk);
        bus.cin_ddm_data = t;
        @(negedge clk);
        bus.cin_ddm_data_wr = 1'b0;
        bus.cin_ddm_data = '0;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [133:0] mk_hdr(logic [2:0] op, logic [7:0] dst,
                                            logic [31:0] addr, logic [31:0] data);
        logic [133:0] h;
        h = '0;
        h[133:132] = 2'b01;
        h[126:124] = op;
        h[123:112] = 12'h123;
        h[111:104] = 8'hAB;
        h[103:96] = dst;
        h[95:64] = addr;
        h[31:0] = data;
        return h;
    endfunction

    logic [133:0] tail_flit;

    task automatic cfg_read(string tag, logic [31:0] addr, logic [31:0] exp);
        logic [133:0] h;
        cfgq.delete();
        cfg_send(mk_hdr(3'b001, 8'd8, addr, 32'h0), tail_flit);
        check({tag, "_nflits"}, 256'(cfgq.size()), 256'(2));
        if (cfgq.size() == 2) begin
            h = cfgq.pop_front();
            check({tag, "_code"}, 256'(h[127:124]), 256'(4'b1011));
            check({tag, "_swap"}, 256'(h[111:96]), 256'(16'h08AB));
            check({tag, "_val"}, 256'(h[31:0]), 256'(exp));
            check({tag, "_tail"}, 256'(cfgq.pop_front()), 256'(tail_flit));
        end
    endtask

    initial begin
        logic [255:0]  md;
        logic [1023:0] pa;
        pkt_t          p;
        int            oerr;
        int            gerr;

        bus.in_ddm_md = '0;
        bus.in_ddm_md_wr = 1'b0;
        bus.in_ddm_phv = '0;
        bus.in_ddm_phv_wr = 1'b0;
        bus.in_ddm_md_alf = 1'b0;
        bus.in_ddm_phv_alf = 1'b0;
        bus.cin_ddm_data = '0;
        bus.cin_ddm_data_wr = 1'b0;
        bus.cin_ddm_ready = 1'b1;
        tail_flit = '0;
        tail_flit[133:132] = 2'b10;
        tail_flit[15:0] = 16'hBEEF;

        repeat (3) @(negedge clk);
        check("rst_md_wr", 256'(bus.out_ddm_md_wr), 256'(0));
        check("rst_phv_wr", 256'(bus.out_ddm_phv_wr), 256'(0));
        check("rst_md", bus.out_ddm_md, 256'(0));
        check("rst_cout_wr", 256'(bus.cout_ddm_data_wr), 256'(0));
        check("rst_cout", 256'(bus.cout_ddm_data), 256'(0));
        check("rst_phv_alf", 256'(bus.out_ddm_phv_alf), 256'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        bus.cin_ddm_ready = 1'b0;
        #1 check("ready_lo", 256'(bus.cout_ddm_ready), 256'(0));
        bus.cin_ddm_ready = 1'b1;
        #1 check("ready_hi", 256'(bus.cout_ddm_ready), 256'(1));

        // local forward
        md = mk_md(8'd5, 1'b0, 12'd100, 32'd1);
        pa = {16{64'h0123_4567_89AB_CDEF}};
        push(md, pa);
        repeat (4) @(negedge clk);
        check("fwd_n", 256'(outq.size()), 256'(1));
        if (outq.size() == 1) begin
            p = outq.pop_front();
            check("fwd_md", p.md, {md[255:88], 8'd6, md[79:0]});
            check("fwd_phv_wr", 256'(p.phv_wr), 256'(1));
            check_phv("fwd_phv", p.phv, pa);
            check("fwd_lat", 256'(p.c - push_cyc), 256'(1));
        end
        cfg_read("rd_fwd1", 32'h8000_0008, 32'd1);

        // three drops of 64 bytes
        for (int i = 0; i < 3; i++) begin
            push(mk_md(8'd5, 1'b1, 12'd64, 32'(10 + i)), mk_phv(32'(10 + i)));
            repeat (2) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("drop_noout", 256'(outq.size()), 256'(0));
        cfg_read("rd_drop", 32'h8000_000A, 32'd3);
        cfg_read("rd_dbyte", 32'h8000_000C, 32'd192);
        cfg_read("rd_dbyte_hi", 32'h8000_000D, 32'd0);

        // bypass
        md = mk_md(8'd9, 1'b1, 12'd77, 32'd20);
        push(md, mk_phv(32'd20));
        repeat (4) @(negedge clk);
        check("byp_n", 256'(outq.size()), 256'(1));
        if (outq.size() == 1) begin
            p = outq.pop_front();
            check("byp_md", p.md, md);
            check_phv("byp_phv", p.phv, mk_phv(32'd20));
        end
        cfg_read("rd_fwd_byp", 32'h8000_0008, 32'd1);
        cfg_read("rd_drop_byp", 32'h8000_000A, 32'd3);

        // unmapped self read and foreign write pass through unchanged
        cfgq.delete();
        cfg_send(mk_hdr(3'b001, 8'd8, 32'h8000_0010, 32'h55), tail_flit);
        check("unmap_n", 256'(cfgq.size()), 256'(2));
        if (cfgq.size() == 2)
            check("unmap_hdr", 256'(cfgq.pop_front()),
                  256'(mk_hdr(3'b001, 8'd8, 32'h8000_0010, 32'h55)));
        cfgq.delete();
        cfg_send(mk_hdr(3'b010, 8'd3, 32'h8000_0000, 32'h1), tail_flit);
        check("fgn_n", 256'(cfgq.size()), 256'(2));
        if (cfgq.size() == 2)
            check("fgn_hdr", 256'(cfgq.pop_front()),
                  256'(mk_hdr(3'b010, 8'd3, 32'h8000_0000, 32'h1)));

        // clear
        cfgq.delete();
        cfg_send(mk_hdr(3'b010, 8'd8, 32'h8000_0000, 32'h1), tail_flit);
        check("clr_noout", 256'(cfgq.size()), 256'(0));
        cfg_read("rd_fwd_clr", 32'h8000_0008, 32'd0);
        cfg_read("rd_drop_clr", 32'h8000_000A, 32'd0);
        cfg_read("rd_dbyte_clr", 32'h8000_000C, 32'd0);

        // clear in the same cycle as a drop pop
        @(negedge clk);
        bus.in_ddm_md = mk_md(8'd5, 1'b1, 12'd40, 32'd30);
        bus.in_ddm_phv = mk_phv(32'd30);
        bus.in_ddm_md_wr = 1'b1;
        bus.in_ddm_phv_wr = 1'b1;
        @(negedge clk);
        bus.in_ddm_md_wr = 1'b0;
        bus.in_ddm_phv_wr = 1'b0;
        bus.cin_ddm_data = mk_hdr(3'b010, 8'd8, 32'h8000_0000, 32'h1);
        bus.cin_ddm_data_wr = 1'b1;
        @(negedge clk);
        bus.cin_ddm_data = tail_flit;
        @(negedge clk);
        bus.cin_ddm_data_wr = 1'b0;
        bus.cin_ddm_data = '0;
        repeat (3) @(negedge clk);
        cfg_read("rd_drop_coll", 32'h8000_000A, 32'd0);
        cfg_read("rd_dbyte_coll", 32'h8000_000C, 32'd0);

        // backpressure: 251 packets held, then drained in order
        outq.delete();
        bus.in_ddm_md_alf = 1'b1;
        for (int i = 0; i <= 250; i++) begin
            @(negedge clk);
            if (i == 250)
                check("bp_alf_250", 256'(bus.out_ddm_phv_alf), 256'(0));
            bus.in_ddm_md = mk_md(8'd9, 1'b0, 12'd1, 32'(i));
            bus.in_ddm_phv = mk_phv(32'(i));
            bus.in_ddm_md_wr = 1'b1;
            bus.in_ddm_phv_wr = 1'b1;
        end
        @(negedge clk);
        bus.in_ddm_md_wr = 1'b0;
        bus.in_ddm_phv_wr = 1'b0;
        check("bp_alf_251", 256'(bus.out_ddm_phv_alf), 256'(1));
        check("bp_md_alf", 256'(bus.out_ddm_md_alf), 256'(1));
        repeat (5) @(negedge clk);
        check("bp_nopop", 256'(outq.size()), 256'(0));
        bus.in_ddm_md_alf = 1'b0;
        repeat (520) @(negedge clk);
        check("bp_drain_n", 256'(outq.size()), 256'(251));
        oerr = 0;
        gerr = 0;
        for (int i = 0; i < outq.size(); i++) begin
            if (outq[i].md[31:0] !== 32'(i)) oerr++;
            if (i > 0 && outq[i].c - outq[i-1].c != 2) gerr++;
        end
        check("bp_order", 256'(oerr), 256'(0));
        check("bp_gap", 256'(gerr), 256'(0));
        check("bp_alf_end", 256'(bus.out_ddm_phv_alf), 256'(0));

        // reset mid-operation empties the FIFOs
        outq.delete();
        bus.in_ddm_md_alf = 1'b1;
        push(mk_md(8'd5, 1'b0, 12'd1, 32'd40), mk_phv(32'd40));
        push(mk_md(8'd5, 1'b0, 12'd1, 32'd41), mk_phv(32'd41));
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.in_ddm_md_alf = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_flush", 256'(outq.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ddm.md
# ddm

Discard/delivery module directly downstream of the statistics stage. It consumes the MD/PHV pair stream and drops every packet addressed to this stage whose MD discard bit is set. Surviving packets are forwarded with the next-module ID rewritten. Per-stage drop/forward counters are exposed for read and clear over the 134-bit configuration chain.

## Interface
- LMID, 8'd5, local module ID; matches the NMID written by the upstream statistics stage.
- NMID, 8'd6, next module ID written into MD[87:80] of forwarded local packets.
- CFG_MID, 8'd8, configuration destination ID of this block.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_ddm_md / in_ddm_md_wr  in  256/1  metadata word and write strobe.
- out_ddm_md_alf  out  1  in_ddm_md_alf OR (MD FIFO count > 250).
- in_ddm_phv / in_ddm_phv_wr  in  1024/1  PHV word and write strobe.
- out_ddm_phv_alf  out  1  in_ddm_phv_alf OR (PHV FIFO count > 250).
- out_ddm_md / out_ddm_md_wr  out  256/1  forwarded metadata.
- in_ddm_md_alf  in  1  downstream MD almost-full.
- out_ddm_phv / out_ddm_phv_wr  out  1024/1  forwarded PHV.
- in_ddm_phv_alf  in  1  downstream PHV almost-full.
- cin_ddm_data / cin_ddm_data_wr  in  134/1  configuration packet input.
- cout_ddm_ready  out  1  equals cin_ddm_ready (combinational).
- cout_ddm_data / cout_ddm_data_wr  out  134/1  configuration packet output.
- cin_ddm_ready  in  1  downstream configuration ready.

## Operation
- MD FIFO: 256x256. PHV FIFO: 1024x256. Both first-word-fall-through; synchronous reset driven from !rst_n.
- Packet FSM states: IDLE_S, GAP_S.
- IDLE_S, pop condition: both FIFOs non-empty AND !in_ddm_md_alf AND !in_ddm_phv_alf. On pop, both FIFOs are popped together.
- Drop: MD[87:80]==LMID AND MD[108]==1. Outputs are not written; drop_pkt_cnt += 1; drop_byte_cnt += {52'b0, MD[107:96]}.
- Local forward: MD[87:80]==LMID AND MD[108]==0. Output MD = {MD[255:88], NMID, MD[79:0]}; fwd_pkt_cnt += 1.
- Bypass: MD[87:80]!=LMID. MD and PHV are forwarded unchanged; no counter changes.
- Every pop moves the FSM to GAP_S. GAP_S returns to IDLE_S after one cycle; the gap lets FIFO flags settle.
- Outside the forward cycle, out_*_wr is 0 and the out_* data is driven to 0.
- Counters are 64-bit and wrap modulo 2^64.
- Config packet format: header flit has [133:132]=01; tail flit has [133:132]=10. Header fields: opcode [126:124] (010 = write, 001 = read), destination [103:96], address [95:64], data [31:0].
- Write to CFG_MID, address 0x8000_0000, data bit0=1: clear_pulse for one cycle, zeroing all three counters. Clear wins over a same-cycle increment. The header and its tail are consumed, not forwarded.
- Read to CFG_MID: header out = {[133:128], 4'b1011, [123:112], [103:96], [111:104], [95:32], value}. The tail is forwarded unchanged.
- Read address map:
  - 0x8000_0008 / 0x8000_0009: fwd_pkt_cnt low / high.
  - 0x8000_000A / 0x8000_000B: drop_pkt_cnt low / high.
  - 0x8000_000C / 0x8000_000D: drop_byte_cnt low / high.
  - Unmapped read address: header forwarded unchanged.
- All other config flits are forwarded unchanged.
- A consumed-write flag is set by a self-addressed write header and cleared by its tail.

## Timing
- Reset values: all out_* data 0, all *_wr 0, cout_ddm_data 0, cout_ddm_data_wr 0, counters 0, FSM = IDLE_S, consumed-write flag 0.
- Packet latency: out_*_wr rises on the clock edge after the pop cycle. Throughput is at most one packet per 2 cycles.
- alf asserted in IDLE_S: no pop occurs and the FIFOs keep the packet.
- Reset mid-operation clears the FIFOs and the FSM immediately. A partially emitted packet never occurs, because the output is a single-cycle flit.
- Config path: cout_ddm_data and cout_ddm_data_wr are registered, 1-cycle latency. Read value is sampled in the header cycle.
- Config read of a counter in the same cycle as its increment returns the pre-increment value.

## Test plan
- Pop mismatch check: MD[87:80]=5, MD[108]=0, PHV=pattern A.
  - Response: out MD[87:80]=6 one cycle after pop, PHV=A, fwd_pkt_cnt=1.
- Drop: MD[87:80]=5, MD[108]=1, length 12'd64, pushed 3 times.
  - Response: no out_*_wr; drop_pkt_cnt=3; drop_byte_cnt=192.
- Bypass: MD[87:80]=9.
  - Response: MD and PHV forwarded bit-identical; all counters unchanged.
- Backpressure: hold in_ddm_md_alf=1 and push 251 packets.
  - Response: no pops; out_ddm_md_alf=1 once count > 250. Release alf: packets drain in order, one per 2 cycles.
- Config readback: after the drop test, send a read header with dest 8, address 0x8000_000A.
  - Response: header [127:124]=1011, [111:104]/[103:96] swapped, [31:0]=3; tail forwarded.
- Config clear: write dest 8, address 0x8000_0000, data 1.
  - Response: nothing emitted on cout; all counters read back 0. A clear colliding with a drop leaves 0.
